// File: rtl/param_cpu_pkg.sv
// rtl/param_cpu_pkg.sv - shared opcodes, state encoding and instruction field layout for param_cpu
//
// Purpose: constants and layout helpers imported by param_cpu and param_cpu_alu.
// Ports: none (package).

package param_cpu_pkg;

  // Opcodes (instruction bits [INSTR_W-1 -: 4])
  localparam logic [3:0] OP_LDI = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_JMP = 4'b1000;
  localparam logic [3:0] OP_JZ  = 4'b1001;
  localparam logic [3:0] OP_JC  = 4'b1010;
  localparam logic [3:0] OP_OUT = 4'b1011;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Control FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // Instruction layout, MSB first: [opcode 4][rd rs_w][rs rs_w][imm data_w]
  function automatic int instr_width(input int rs_w, input int data_w);
    return 4 + 2 * rs_w + data_w;
  endfunction

  function automatic int op_lsb(input int rs_w, input int data_w);
    return 2 * rs_w + data_w;
  endfunction

  function automatic int rd_lsb(input int rs_w, input int data_w);
    return rs_w + data_w;
  endfunction

  function automatic int rs_lsb(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/param_cpu_alu.sv
// rtl/param_cpu_alu.sv - combinational ALU for param_cpu
//
// Purpose: computes ADD/SUB/AND/OR/XOR on DATA_W-bit unsigned operands.
// Ports:
//   a, b    in  DATA_W  operands (a = rd value, b = rs value)
//   op      in  4       opcode
//   result  out DATA_W  result, modulo 2^DATA_W
//   c       out 1       ADD carry-out / SUB borrow (a<b) / 0 for logic ops
//   z       out 1       result == 0

module param_cpu_alu
  import param_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              z
);

  // One extra bit holds the carry/borrow out of the top of the word.
  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    c    = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        c    = wide[DATA_W];
      end
      OP_SUB: begin
        // Borrow appears in the extra bit exactly when a < b.
        wide = {1'b0, a} - {1'b0, b};
        c    = wide[DATA_W];
      end
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      default: wide = {1'b0, b};
    endcase
    result = wide[DATA_W-1:0];
    z      = (result == '0);
  end

endmodule

// File: rtl/param_cpu.sv
// rtl/param_cpu.sv - parametrised two-cycle-per-instruction CPU with program-load port
//
// Purpose: FETCH/EXEC CPU with register file, Z/C flags, jumps, output port and
// host-writable instruction memory.
// Ports:
//   clk        in  1        clock
//   reset      in  1        asynchronous, active-high
//   start      in  1        run from address 0 (IDLE/HALT only)
//   prog_we    in  1        instruction-memory write strobe (IDLE/HALT only)
//   prog_addr  in  PC_W     write address
//   prog_data  in  INSTR_W  write data
//   out_data   out DATA_W   last value emitted by OUT
//   out_valid  out 1        one-cycle pulse when out_data updates
//   busy       out 1        FETCH or EXEC
//   halted     out 1        HALT

module param_cpu
  import param_cpu_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int NREGS      = 4,
  parameter  int IMEM_DEPTH = 16,
  localparam int RS_W       = $clog2(NREGS),
  localparam int PC_W       = $clog2(IMEM_DEPTH),
  localparam int INSTR_W    = instr_width(RS_W, DATA_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic               busy,
  output logic               halted
);

  localparam int OP_LSB = op_lsb(RS_W, DATA_W);
  localparam int RD_LSB = rd_lsb(RS_W, DATA_W);
  localparam int RS_LSB = rs_lsb(DATA_W);

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0]  regs_q [NREGS];
  logic [DATA_W-1:0]  regs_d [NREGS];
  logic               z_q, z_d;
  logic               c_q, c_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  // Not reset: program contents survive reset and HALT.
  logic [INSTR_W-1:0] imem [IMEM_DEPTH];

  logic               stopped;
  logic [3:0]         opcode;
  logic [RS_W-1:0]    rd;
  logic [RS_W-1:0]    rs;
  logic [DATA_W-1:0]  imm;
  logic [DATA_W-1:0]  rd_val;
  logic [DATA_W-1:0]  rs_val;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_c;
  logic               alu_z;

  assign stopped = (state_q == ST_IDLE) || (state_q == ST_HALT);
  assign opcode  = instr_q[OP_LSB +: 4];
  assign rd      = instr_q[RD_LSB +: RS_W];
  assign rs      = instr_q[RS_LSB +: RS_W];
  assign imm     = instr_q[DATA_W-1:0];
  assign rd_val  = regs_q[rd];
  assign rs_val  = regs_q[rs];

  param_cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (rd_val),
    .b      (rs_val),
    .op     (opcode),
    .result (alu_result),
    .c      (alu_c),
    .z      (alu_z)
  );

  // A write and a start on the same edge both land; the FETCH that follows
  // reads the freshly written word.
  always_ff @(posedge clk) begin
    if (prog_we && stopped) begin
      imem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    regs_d      = regs_q;
    z_d         = z_q;
    c_d         = c_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          z_d     = 1'b0;
          c_d     = 1'b0;
          for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = '0;
          end
        end
      end
      ST_FETCH: begin
        instr_d = imem[pc_q];
        pc_d    = pc_q + PC_W'(1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (opcode)
          OP_LDI: regs_d[rd] = imm;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            regs_d[rd] = alu_result;
            z_d        = alu_z;
            c_d        = alu_c;
          end
          OP_MOV: regs_d[rd] = rs_val;
          // Jumps replace the pc+1 already written during FETCH.
          OP_JMP: pc_d = imm[PC_W-1:0];
          OP_JZ:  if (z_q) pc_d = imm[PC_W-1:0];
          OP_JC:  if (c_q) pc_d = imm[PC_W-1:0];
          OP_OUT: begin
            out_data_d  = rs_val;
            out_valid_d = 1'b1;
          end
          OP_HLT:  state_d = ST_HALT;
          default: ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      z_q         <= z_d;
      c_q         <= c_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign halted    = (state_q == ST_HALT);

endmodule
